// File: rtl/exp_datapath_pkg.sv
// Shared definitions for the square-and-multiply exponentiator: control-word
// layout and select encodings used by both the controller and the datapath.
package exp_pkg;

  localparam int unsigned CTRL_BITS = 8;

  // Control word bit positions, MSB to LSB
  localparam int unsigned CB_LOADA    = 7;
  localparam int unsigned CB_LOADCOUN = 6;
  localparam int unsigned CB_LOADB    = 5;
  localparam int unsigned CB_SHIFTB   = 4;
  localparam int unsigned CB_LOADC    = 3;
  localparam int unsigned CB_SCOUN    = 2;
  localparam int unsigned CB_SC_HI    = 1;
  localparam int unsigned CB_SC_LO    = 0;

  typedef enum logic [1:0] {
    SC_ONE  = 2'b00,
    SC_SQR  = 2'b01,
    SC_MUL  = 2'b10,
    SC_HOLD = 2'b11
  } sc_sel_e;

  typedef enum logic {
    SCOUN_LOAD = 1'b0,
    SCOUN_DEC  = 1'b1
  } scoun_sel_e;

  typedef logic [CTRL_BITS-1:0] ctrl_word_t;

  function automatic ctrl_word_t make_ctrl(
    input logic       load_a,
    input logic       load_coun,
    input logic       load_b,
    input logic       shift_b,
    input logic       load_c,
    input scoun_sel_e s_coun,
    input sc_sel_e    s_c
  );
    ctrl_word_t w;
    w                     = '0;
    w[CB_LOADA]           = load_a;
    w[CB_LOADCOUN]        = load_coun;
    w[CB_LOADB]           = load_b;
    w[CB_SHIFTB]          = shift_b;
    w[CB_LOADC]           = load_c;
    w[CB_SCOUN]           = s_coun;
    w[CB_SC_HI:CB_SC_LO]  = s_c;
    return w;
  endfunction

endpackage

// File: rtl/exp_datapath_if.sv
// Controller-to-datapath bus: operand inputs, 8-bit control word fields and
// the status/result returned to the controller.
interface exp_datapath_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         LoadA;
  logic         LoadCoun;
  logic         LoadB;
  logic         ShiftB;
  logic         LoadC;
  logic         S_Coun;
  logic [1:0]   S_C;
  logic         equals;
  logic         prevRegB;
  logic [W-1:0] result;

  modport master (
    output a_in, b_in, LoadA, LoadCoun, LoadB, ShiftB, LoadC, S_Coun, S_C,
    input  equals, prevRegB, result
  );

  modport slave (
    input  a_in, b_in, LoadA, LoadCoun, LoadB, ShiftB, LoadC, S_Coun, S_C,
    output equals, prevRegB, result
  );
endinterface

// File: rtl/exp_bit_counter.sv
// Exponent bit counter: loads W or decrements (saturating at zero);
// equals flags the exhausted count.
module exp_bit_counter
  import exp_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_en,
  input  scoun_sel_e sel,
  output logic       equals
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load_en) begin
      if (sel == SCOUN_LOAD) begin
        cnt <= CW'(W);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign equals = (cnt == '0);

endmodule

// File: rtl/exp_datapath.sv
// Datapath of the left-to-right square-and-multiply exponentiator; executes
// the control word each cycle and returns equals/prevRegB to the controller.
module exp_datapath
  import exp_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input logic           clk,
  input logic           rst_n,
  exp_datapath_if.slave bus
);

  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] c_q;
  logic [W-1:0] c_next;
  sc_sel_e      sc_sel;

  assign sc_sel = sc_sel_e'(bus.S_C);

  // W-bit products keep only the low W bits of the full product (mod 2^W);
  // operands are the pre-edge registers, so LoadA with SC_MUL uses old A.
  always_comb begin
    c_next = c_q;
    unique case (sc_sel)
      SC_ONE:  c_next = W'(1);
      SC_SQR:  c_next = c_q * c_q;
      SC_MUL:  c_next = c_q * a_q;
      SC_HOLD: c_next = c_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= W'(1);
    end else begin
      if (bus.LoadA) begin
        a_q <= bus.a_in;
      end
      if (bus.LoadB) begin
        b_q <= bus.b_in;
      end else if (bus.ShiftB) begin
        b_q <= {b_q[W-2:0], 1'b0};
      end
      if (bus.LoadC) begin
        c_q <= c_next;
      end
    end
  end

  exp_bit_counter #(
    .W (W)
  ) u_bit_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (bus.LoadCoun),
    .sel     (scoun_sel_e'(bus.S_Coun)),
    .equals  (bus.equals)
  );

  assign bus.prevRegB = b_q[W-1];
  assign bus.result   = c_q;

endmodule

// File: tb/tb_exp_datapath.sv
// Directed bench for exp_datapath with an arithmetic reference model and a
// per-cycle compare process on the falling edge.
module tb_exp_datapath;
  import exp_pkg::*;

  localparam int unsigned W   = 8;
  localparam int unsigned MOD = 256;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;
  bit   cmp_on = 0;

  // Reference state, held as plain integers
  int unsigned m_a, m_b, m_c, m_cnt;

  exp_datapath_if #(.W(W)) bus ();

  exp_datapath #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_c = 1; m_cnt = 0;
  endtask

  task automatic model_step(input ctrl_word_t w, input int unsigned a, input int unsigned b);
    int unsigned nc;
    nc = m_c;
    if (w[CB_LOADC]) begin
      case (w[CB_SC_HI:CB_SC_LO])
        2'b00: nc = 1;
        2'b01: nc = (m_c * m_c) % MOD;
        2'b10: nc = (m_c * m_a) % MOD;
        default: nc = m_c;
      endcase
    end
    if (w[CB_LOADA]) m_a = a;
    if (w[CB_LOADB]) m_b = b;
    else if (w[CB_SHIFTB]) m_b = (m_b * 2) % MOD;
    if (w[CB_LOADCOUN]) begin
      if (!w[CB_SCOUN]) m_cnt = W;
      else if (m_cnt > 0) m_cnt = m_cnt - 1;
    end
    m_c = nc;
  endtask

  task automatic cycle(input ctrl_word_t w, input logic [7:0] a = 8'h00, input logic [7:0] b = 8'h00);
    bus.a_in     = a;
    bus.b_in     = b;
    bus.LoadA    = w[CB_LOADA];
    bus.LoadCoun = w[CB_LOADCOUN];
    bus.LoadB    = w[CB_LOADB];
    bus.ShiftB   = w[CB_SHIFTB];
    bus.LoadC    = w[CB_LOADC];
    bus.S_Coun   = w[CB_SCOUN];
    bus.S_C      = w[CB_SC_HI:CB_SC_LO];
    @(posedge clk);
    if (rst_n) model_step(w, a, b);
    else model_reset();
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cmp_result", bus.result, m_c);
      check("cmp_equals", bus.equals, m_cnt == 0);
      check("cmp_prevRegB", bus.prevRegB, m_b >= 128);
    end
  end

  ctrl_word_t idle, w_init, w_dec, w_sqr, w_mul, w_shift, w_loadcnt;

  task automatic run_exp(input logic [7:0] a, input logic [7:0] b, input int unsigned expect_c, input string tag);
    int iter;
    cycle(w_init, a, b);
    check({tag, "_init_c"}, bus.result, 1);
    check({tag, "_init_equals"}, bus.equals, 0);
    iter = 0;
    while (!bus.equals && iter < 20) begin
      cycle(w_dec);
      cycle(w_sqr);
      if (bus.prevRegB) cycle(w_mul);
      cycle(w_shift);
      iter++;
    end
    check({tag, "_iterations"}, iter, 8);
    check({tag, "_result"}, bus.result, expect_c);
  endtask

  initial begin
    idle      = '0;
    w_init    = make_ctrl(1, 1, 1, 0, 1, SCOUN_LOAD, SC_ONE);
    w_dec     = make_ctrl(0, 1, 0, 0, 0, SCOUN_DEC,  SC_ONE);
    w_sqr     = make_ctrl(0, 0, 0, 0, 1, SCOUN_LOAD, SC_SQR);
    w_mul     = make_ctrl(0, 0, 0, 0, 1, SCOUN_LOAD, SC_MUL);
    w_shift   = make_ctrl(0, 0, 0, 1, 0, SCOUN_LOAD, SC_ONE);
    w_loadcnt = make_ctrl(0, 1, 0, 0, 0, SCOUN_LOAD, SC_ONE);

    rst_n = 1'b0;
    model_reset();
    cycle(idle);
    cycle(idle);
    check("reset_result", bus.result, 1);
    check("reset_equals", bus.equals, 1);
    check("reset_prevRegB", bus.prevRegB, 0);
    cmp_on = 1;
    rst_n  = 1'b1;

    run_exp(8'd3, 8'd5, 243, "exp3_5");
    run_exp(8'd3, 8'd6, 217, "exp3_6");
    run_exp(8'd2, 8'd8, 0,   "exp2_8");

    cycle(w_loadcnt);
    check("sat_loaded", bus.equals, 0);
    for (int k = 1; k <= 10; k++) begin
      cycle(w_dec);
      check($sformatf("sat_equals_after_%0d", k), bus.equals, k >= 8);
    end

    cycle(make_ctrl(0, 0, 1, 1, 0, SCOUN_LOAD, SC_ONE), 8'h00, 8'h81);
    check("prio_load_b", bus.prevRegB, 1);
    cycle(w_shift);
    check("prio_shift_b", bus.prevRegB, 0);
    cycle(make_ctrl(1, 0, 0, 0, 1, SCOUN_LOAD, SC_ONE), 8'd2);
    cycle(w_mul);
    check("prio_c_is_2", bus.result, 2);
    cycle(make_ctrl(1, 0, 0, 0, 0, SCOUN_LOAD, SC_ONE), 8'd3);
    cycle(make_ctrl(1, 0, 0, 0, 1, SCOUN_LOAD, SC_MUL), 8'd5);
    check("prio_old_a_mul", bus.result, 6);
    cycle(w_mul);
    check("prio_new_a_mul", bus.result, 30);

    for (int k = 0; k < 4; k++) begin
      cycle((k < 2) ? make_ctrl(0, 0, 0, 0, 1, SCOUN_LOAD, SC_HOLD) : idle, 8'hff, 8'hff);
      check($sformatf("hold_result_%0d", k), bus.result, 30);
      check($sformatf("hold_equals_%0d", k), bus.equals, 1);
    end

    run_exp(8'd3, 8'd4, 81, "exp3_4");
    cycle(make_ctrl(0, 1, 1, 0, 0, SCOUN_LOAD, SC_ONE), 8'h00, 8'h80);
    check("pre_reset_c", bus.result, 32'h51);
    check("pre_reset_prevRegB", bus.prevRegB, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_c", bus.result, 1);
    check("async_reset_equals", bus.equals, 1);
    check("async_reset_prevRegB", bus.prevRegB, 0);
    for (int k = 0; k < 5; k++) cycle(w_init, 8'd7, 8'hff);
    check("reset_hold_c", bus.result, 1);
    rst_n = 1'b1;
    cycle(w_init, 8'd7, 8'h80);
    check("post_reset_prevRegB", bus.prevRegB, 1);
    cycle(w_mul);
    check("post_reset_mul", bus.result, 7);
    cycle(idle);

    cmp_on = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
